// File: rtl/fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// fft_stage_ctrl
//
// Sequencer for one radix-2 single-path delay-feedback (SDF) FFT stage.
// Counts accepted input samples per frame. For every accepted sample, and for
// every cycle of the delay-line flush that follows a frame, it produces the
// registered datapath controls:
//   - the datapath mode
//   - the twiddle ROM address and enable
//   - the output-valid strobe
//
// All outputs are registered. The controls for a sample accepted at a clock
// edge are visible from that edge until the next one. This lines them up with
// the datapath input register.
//
// Parameters
//   N     FFT length, power of two, >= 4
//   D     delay-line depth of this stage, power of two, 1 <= D <= N/2
//   TW_W  twiddle address width, log2(N/2)
//
// Ports
//   clk_i         clock, rising edge
//   reset_i       synchronous reset, active low
//   in_valid_i    a sample is presented to the stage this cycle
//   state_o       datapath mode: 0 idle/stall, 1 fill/delay, 2 butterfly
//   tw_addr_o     twiddle ROM index
//   tw_en_o       twiddle multiply active
//   out_valid_o   stage output valid
//   frame_done_o  pulse on the Nth output of a frame (last flush cycle)
//   busy_o        a frame is in progress
//   err_o         sticky overrun flag (in_valid during flush)
//
// Build option
//   FFT_CTRL_ERR_EN  when defined, builds the overrun detector behind err_o.
//                    When undefined, err_o is tied low.
//
// FSM states
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no frame in progress; the next in_valid starts a frame at cnt=0
//   ST_RUN   | accepting samples 1..N-1; stalls while in_valid is low
//   ST_DRAIN | flushing the delay line for D cycles; input is ignored
// -----------------------------------------------------------------------------
module fft_stage_ctrl #(
   parameter int N    = 32,
   parameter int D    = 16,
   parameter int TW_W = 4
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            in_valid_i,
   output logic [1:0]      state_o,
   output logic [TW_W-1:0] tw_addr_o,
   output logic            tw_en_o,
   output logic            out_valid_o,
   output logic            frame_done_o,
   output logic            busy_o,
   output logic            err_o
);

   localparam int LOGN = $clog2(N);
   localparam int LOGD = $clog2(D);
   // D = 1 would give a zero-width drain counter; keep one bit that stays 0.
   localparam int DW   = (LOGD > 0) ? LOGD : 1;
   localparam int S    = LOGN - 1 - LOGD;

   localparam logic [LOGN-1:0] CNT_LAST  = LOGN'(N - 1);
   localparam logic [LOGN-1:0] K_MASK    = LOGN'(D - 1);
   localparam logic [DW-1:0]   DCNT_LAST = DW'(D - 1);

   localparam logic [1:0] MODE_IDLE = 2'd0;
   localparam logic [1:0] MODE_FILL = 2'd1;
   localparam logic [1:0] MODE_BFLY = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fsm_e;

   fsm_e            fsm_q, fsm_d;
   logic [LOGN-1:0] cnt_q, cnt_d;
   logic [DW-1:0]   dcnt_q, dcnt_d;

   logic [1:0]      state_q, state_d;
   logic [TW_W-1:0] tw_addr_q, tw_addr_d;
   logic            tw_en_q, tw_en_d;
   logic            out_valid_q, out_valid_d;
   logic            frame_done_q, frame_done_d;
   logic            busy_q, busy_d;

`ifdef FFT_CTRL_ERR_EN
   logic            err_q, err_d;
`endif

   // Counter field decode. Shifting cnt right by LOGD+1 gives blk; when
   // D = N/2 the shift consumes every bit and blk is 0.
   logic            phase_w;
   logic [LOGN-1:0] blk_w;
   logic [LOGN-1:0] k_w;
   logic [TW_W-1:0] tw_samp_w;
   logic [TW_W-1:0] tw_drain_w;

   assign phase_w    = cnt_q[LOGD];
   assign blk_w      = cnt_q >> (LOGD + 1);
   assign k_w        = cnt_q & K_MASK;
   // (D-1) << S is always below N/2, so truncating to TW_W bits never wraps.
   assign tw_samp_w  = TW_W'(k_w << S);
   assign tw_drain_w = TW_W'(LOGN'(dcnt_q) << S);

   always_comb begin
      fsm_d        = fsm_q;
      cnt_d        = cnt_q;
      dcnt_d       = dcnt_q;
      state_d      = MODE_IDLE;
      tw_addr_d    = '0;
      tw_en_d      = 1'b0;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      busy_d       = 1'b0;
`ifdef FFT_CTRL_ERR_EN
      err_d        = err_q;
`endif

      case (fsm_q)
         ST_IDLE, ST_RUN: begin
            if (in_valid_i) begin
               busy_d = 1'b1;
               if (phase_w) begin
                  state_d     = MODE_BFLY;
                  out_valid_d = 1'b1;
               end else if (blk_w != '0) begin
                  state_d     = MODE_FILL;
                  out_valid_d = 1'b1;
                  tw_en_d     = 1'b1;
                  tw_addr_d   = tw_samp_w;
               end else begin
                  // First half of the first block: delay line still filling.
                  state_d = MODE_FILL;
               end

               if (cnt_q == CNT_LAST) begin
                  fsm_d  = ST_DRAIN;
                  cnt_d  = '0;
                  dcnt_d = '0;
               end else begin
                  fsm_d = ST_RUN;
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               // Stall mid-frame keeps busy high; true idle drops it.
               busy_d = (fsm_q == ST_RUN);
            end
         end

         ST_DRAIN: begin
            busy_d      = 1'b1;
            state_d     = MODE_FILL;
            out_valid_d = 1'b1;
            tw_en_d     = 1'b1;
            tw_addr_d   = tw_drain_w;
`ifdef FFT_CTRL_ERR_EN
            if (in_valid_i) begin
               err_d = 1'b1;
            end
`endif
            if (dcnt_q == DCNT_LAST) begin
               frame_done_d = 1'b1;
               fsm_d        = ST_IDLE;
               dcnt_d       = '0;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end

         default: begin
            fsm_d  = ST_IDLE;
            cnt_d  = '0;
            dcnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         fsm_q        <= ST_IDLE;
         cnt_q        <= '0;
         dcnt_q       <= '0;
         state_q      <= MODE_IDLE;
         tw_addr_q    <= '0;
         tw_en_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef FFT_CTRL_ERR_EN
         err_q        <= 1'b0;
`endif
      end else begin
         fsm_q        <= fsm_d;
         cnt_q        <= cnt_d;
         dcnt_q       <= dcnt_d;
         state_q      <= state_d;
         tw_addr_q    <= tw_addr_d;
         tw_en_q      <= tw_en_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
`ifdef FFT_CTRL_ERR_EN
         err_q        <= err_d;
`endif
      end
   end

   assign state_o      = state_q;
   assign tw_addr_o    = tw_addr_q;
   assign tw_en_o      = tw_en_q;
   assign out_valid_o  = out_valid_q;
   assign frame_done_o = frame_done_q;
   assign busy_o       = busy_q;

`ifdef FFT_CTRL_ERR_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_stage_ctrl
//
// Drives two controllers, both with N=32: one with D=16 and one with D=4.
// Both see the same in_valid/reset sequence. Every output is compared each
// cycle against a sample-index reference model.
// -----------------------------------------------------------------------------
module tb_fft_stage_ctrl;

`ifdef FFT_CTRL_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam int NN = 32;

   logic       clk;
   logic       rst_n;
   logic       iv;

   logic [1:0] st0, st1;
   logic [3:0] tw0, tw1;
   logic       twen0, twen1, ov0, ov1, fd0, fd1, bz0, bz1, er0, er1;

   fft_stage_ctrl #(.N(32), .D(16), .TW_W(4)) u0 (
      .clk_i(clk), .reset_i(rst_n), .in_valid_i(iv),
      .state_o(st0), .tw_addr_o(tw0), .tw_en_o(twen0), .out_valid_o(ov0),
      .frame_done_o(fd0), .busy_o(bz0), .err_o(er0));

   fft_stage_ctrl #(.N(32), .D(4), .TW_W(4)) u1 (
      .clk_i(clk), .reset_i(rst_n), .in_valid_i(iv),
      .state_o(st1), .tw_addr_o(tw1), .tw_en_o(twen1), .out_valid_o(ov1),
      .frame_done_o(fd1), .busy_o(bz1), .err_o(er1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0] st;
      logic [3:0] tw;
      logic       twen;
      logic       ov;
      logic       fd;
      logic       busy;
      logic       err;
   } exp_t;

   // Reference model state per instance.
   // m_mode: 0 = no frame, 1 = mid-frame, 2 = flushing.
   int m_mode [2];
   int m_s    [2];
   int m_j    [2];
   bit m_err  [2];

   int passed = 0;
   int total  = 0;
   int ovc0, ovc1;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // Expected registered outputs after the coming clock edge.
   task automatic model(input int u, input int d, input bit iv_in, input bit rst_in,
                        output exp_t e);
      int sh, ph, blk, k;
      sh = NN / (2 * d);
      e.st = 2'd0; e.tw = 4'd0; e.twen = 1'b0; e.ov = 1'b0;
      e.fd = 1'b0; e.busy = 1'b0; e.err = 1'b0;
      if (!rst_in) begin
         m_mode[u] = 0; m_s[u] = 0; m_j[u] = 0; m_err[u] = 1'b0;
      end else if (m_mode[u] == 2) begin
         e.st = 2'd1; e.ov = 1'b1; e.twen = 1'b1;
         e.tw = 4'(m_j[u] * sh);
         e.fd = (m_j[u] == d - 1);
         e.busy = 1'b1;
         if (iv_in && ERR_EN) m_err[u] = 1'b1;
         m_j[u]++;
         if (m_j[u] == d) begin
            m_mode[u] = 0; m_j[u] = 0;
         end
      end else if (iv_in) begin
         ph  = (m_s[u] / d) % 2;
         blk = m_s[u] / (2 * d);
         k   = m_s[u] % d;
         e.busy = 1'b1;
         if (ph == 1) begin
            e.st = 2'd2; e.ov = 1'b1;
         end else if (blk > 0) begin
            e.st = 2'd1; e.ov = 1'b1; e.twen = 1'b1; e.tw = 4'(k * sh);
         end else begin
            e.st = 2'd1;
         end
         m_s[u]++;
         if (m_s[u] == NN) begin
            m_mode[u] = 2; m_s[u] = 0; m_j[u] = 0;
         end else begin
            m_mode[u] = 1;
         end
      end else begin
         e.busy = (m_mode[u] == 1);
      end
      e.err = m_err[u];
   endtask

   task automatic cycle(input bit iv_in, input bit rst_in);
      exp_t e0, e1;
      iv    = iv_in;
      rst_n = rst_in;
      model(0, 16, iv_in, rst_in, e0);
      model(1, 4,  iv_in, rst_in, e1);
      @(posedge clk);
      #1;
      chk("u0.state",      8'(st0),   8'(e0.st));
      chk("u0.tw_addr",    8'(tw0),   8'(e0.tw));
      chk("u0.tw_en",      8'(twen0), 8'(e0.twen));
      chk("u0.out_valid",  8'(ov0),   8'(e0.ov));
      chk("u0.frame_done", 8'(fd0),   8'(e0.fd));
      chk("u0.busy",       8'(bz0),   8'(e0.busy));
      chk("u0.err",        8'(er0),   8'(e0.err));
      chk("u1.state",      8'(st1),   8'(e1.st));
      chk("u1.tw_addr",    8'(tw1),   8'(e1.tw));
      chk("u1.tw_en",      8'(twen1), 8'(e1.twen));
      chk("u1.out_valid",  8'(ov1),   8'(e1.ov));
      chk("u1.frame_done", 8'(fd1),   8'(e1.fd));
      chk("u1.busy",       8'(bz1),   8'(e1.busy));
      chk("u1.err",        8'(er1),   8'(e1.err));
      if (ov0 === 1'b1) ovc0++;
      if (ov1 === 1'b1) ovc1++;
   endtask

   initial begin
      iv    = 1'b0;
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         m_mode[u] = 0; m_s[u] = 0; m_j[u] = 0; m_err[u] = 1'b0;
      end

      // Reset state
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);

      // Single gap-free frame plus flush
      ovc0 = 0; ovc1 = 0;
      for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
      chk("frame1.ov_count_d16", 8'(ovc0), 8'd32);
      chk("frame1.ov_count_d4",  8'(ovc1), 8'd32);

      // Two frames, second starting right after the D=16 flush ends
      ovc0 = 0; ovc1 = 0;
      for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1);
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1);
      for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
      chk("b2b.ov_count_d16", 8'(ovc0), 8'd64);
      chk("b2b.ov_count_d4",  8'(ovc1), 8'd64);

      // Alternating in_valid with stalls
      ovc0 = 0; ovc1 = 0;
      for (int i = 0; i < 64; i++) cycle(((i % 2) == 0), 1'b1);
      for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1);
      chk("toggle.ov_count_d16", 8'(ovc0), 8'd32);
      chk("toggle.ov_count_d4",  8'(ovc1), 8'd32);

      // Random in_valid, including presses during the flush
      for (int i = 0; i < 400; i++) cycle(($urandom_range(0, 3) != 0), 1'b1);
      for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1);

      // in_valid held high through the flush
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 48; i++) cycle(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);

      // Reset mid-frame at cnt=9, then a fresh frame
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b0);
      ovc0 = 0; ovc1 = 0;
      for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
      chk("post_reset.ov_count_d16", 8'(ovc0), 8'd32);
      chk("post_reset.ov_count_d4",  8'(ovc1), 8'd32);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Sequencer for one radix-2 single-path delay-feedback (SDF) stage of the 32-point FFT pipeline. It counts accepted input samples per frame and drives the stage datapath. For each sample it selects the datapath mode (fill/delay vs. butterfly), the twiddle ROM address and its enable, and the output-valid strobe. After the last input of a frame it flushes the delay line. One instance sits beside each stage's butterfly, delay line and twiddle ROM.

## Interface
- `N`, default 32: FFT length. Power of two, ≥ 4. LOGN = log2(N).
- `D`, default 16: stage delay-line depth. Power of two, 1 ≤ D ≤ N/2. LOGD = log2(D).
- `TW_W`, default 4: twiddle address width, = log2(N/2). S = LOGN−1−LOGD is the address shift.
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: one input sample is presented to the stage this cycle.
- `state`, output, 2: datapath mode. 0 = idle/stall, 1 = fill/delay (delayed-difference path), 2 = butterfly.
- `tw_addr`, output, TW_W: twiddle ROM index.
- `tw_en`, output, 1: the twiddle multiply is active this cycle.
- `out_valid`, output, 1: the stage output is valid this cycle.
- `frame_done`, output, 1: one-cycle pulse coinciding with the Nth output of a frame.
- `busy`, output, 1: FSM is not IDLE.
- `err`, output, 1: sticky overrun flag (see Configuration).

## Operation
- FSM states are IDLE, RUN and DRAIN. Sample counter `cnt` is LOGN bits. Drain counter `dcnt` is LOGD bits.
- Counter field decode:
  - blk = cnt[LOGN−1:LOGD+1] (empty when D = N/2; treat blk as 0).
  - phase = cnt[LOGD].
  - k = cnt[LOGD−1:0].
- IDLE: in_valid=1 accepts a sample with cnt=0, then goes to RUN with cnt=1.
- RUN:
  - in_valid=1 accepts a sample and increments cnt.
  - in_valid=0 stalls: cnt is held and the cycle's outputs are the idle set.
  - Accepting the sample with cnt=N−1 sets cnt=0, dcnt=0 and moves to DRAIN.
- DRAIN: advances every cycle regardless of in_valid. After the cycle with dcnt=D−1 it returns to IDLE.
- Output decode for an accepted sample (phase, k, blk):
  - phase=1: state=2, out_valid=1, tw_en=0, tw_addr=0.
  - phase=0, blk>0: state=1, out_valid=1, tw_en=1, tw_addr=k<<S.
  - phase=0, blk=0: state=1, out_valid=0, tw_en=0, tw_addr=0 (delay line filling).
- Output decode for a DRAIN cycle: state=1, out_valid=1, tw_en=1, tw_addr=dcnt<<S. frame_done=1 when dcnt=D−1.
- Idle or stall cycle: state=0, out_valid=0, tw_en=0, tw_addr=0, frame_done=0.
- Each frame produces exactly N out_valid cycles: N/2 butterfly outputs plus N/2 delayed-difference outputs.
- tw_addr arithmetic: k<<S truncated to TW_W bits. The maximum value (D−1)<<S is always < N/2, so no wrap occurs.
- in_valid=1 during DRAIN is ignored: no sample accepted, cnt unchanged. With ERR_EN, err is set.
- Reset (reset=0 at a clock edge), at any point in any state: FSM→IDLE, cnt=0, dcnt=0, err=0. All outputs are 0 from the following cycle.

## Timing
- All outputs are registered.
- Outputs for the sample accepted at edge t, or for the DRAIN cycle at edge t, are visible from t until edge t+1. This is 1-cycle latency, aligned to the datapath input register.
- busy rises in the cycle after the first accepted sample. It falls in the cycle after the last DRAIN cycle.
- A new frame may start in the first cycle after DRAIN ends; there are no dead cycles beyond IDLE.
- Minimum frame time is N + D cycles with continuous in_valid.

## Configuration
- `FFT_CTRL_ERR_EN`:
  - Defined: err is set when in_valid=1 in DRAIN and stays 1 until reset.
  - Undefined: err is tied to 0 and no overrun logic is built.
  - All other behaviour is identical in both builds.

## Test plan
- N=32, D=16, 32 consecutive in_valid:
  - Output cycles 1–16: state=1, out_valid=0.
  - Output cycles 17–32: state=2, out_valid=1.
  - Then 16 DRAIN cycles: tw_addr 0..15, tw_en=1; frame_done only on the last; busy drops the next cycle.
- N=32, D=4: outputs for samples 8–11 (blk=1, phase 0) give tw_addr 0,4,8,12 with tw_en=1. Samples 0–3 give out_valid=0. The frame totals exactly 32 out_valid cycles.
- in_valid toggling 1,0,1,0 mid-frame: stall cycles output state=0 with cnt held. The out_valid count and tw_addr sequence match the gap-free run.
- in_valid held high through DRAIN with ERR_EN defined: err=1 from that point; DRAIN still lasts D cycles. Without the macro, err stays 0.
- reset=0 asserted mid-RUN at cnt=9: all outputs are 0 the next cycle. A fresh frame afterwards behaves as in the first test.
- Two frames back-to-back (in_valid resumes the first cycle after DRAIN ends): the second frame reproduces the first test's output sequence exactly.
